cdb_arbiter: RTL

Common Data Bus (CDB) arbiter: the transmit end of the `expipe_pkg::cdb_data_t` result bus. It collects completed results from all execution units and grants one per cycle with round-robin priority. It registers the winner and broadcasts it to the ROB and reservation stations with a valid/ready handshake. It sits between the EU result ports and the commit unit's CDB input.

---
 rtl/cdb_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant of EU results onto a registered
// result bus with a valid/ready handshake toward the ROB.
package expipe_pkg;
  localparam int EU_N = 4;

  typedef struct packed {
    logic [5:0]  rob_idx;
    logic [31:0] res_value;
    logic        except_raised;
    logic [4:0]  except_code;
    logic [4:0]  flags;
  } cdb_data_t;
endpackage

module cdb_arbiter
  import expipe_pkg::*;
#(
  parameter int N_EU = EU_N
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [N_EU-1:0]       eu_valid_i,
  output logic [N_EU-1:0]       eu_ready_o,
  input  cdb_data_t [N_EU-1:0]  eu_data_i,
  output logic                  cdb_valid_o,
  input  logic                  cdb_ready_i,
  output cdb_data_t             cdb_data_o
);

  localparam int PW = $clog2(N_EU);

  cdb_data_t     out_q;
  logic          valid_q;
  logic [PW-1:0] prio_q;

  logic          load_en;
  logic          found;
  logic          grant;
  logic [PW-1:0] winner;
  logic [PW-1:0] prio_nxt;
  logic [PW:0]   sum;

  // Register is free or drains this cycle; held low in reset so no
  // EU handshake completes while the state is being cleared.
  assign load_en = ~rst_i & ~flush_i & (~valid_q | cdb_ready_i);

  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int k = 0; k < N_EU; k++) begin
      sum = {1'b0, prio_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_EU))
        sum = sum - (PW+1)'(N_EU);
      if (!found && eu_valid_i[sum[PW-1:0]]) begin
        found  = 1'b1;
        winner = sum[PW-1:0];
      end
    end
  end

  assign grant = load_en & found;

  always_comb begin
    eu_ready_o = '0;
    if (grant)
      eu_ready_o[winner] = 1'b1;
  end

  always_comb begin
    if (winner == PW'(N_EU - 1))
      prio_nxt = '0;
    else
      prio_nxt = winner + PW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      prio_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_en) begin
      if (found) begin
        out_q   <= eu_data_i[winner];
        valid_q <= 1'b1;
        prio_q  <= prio_nxt;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign cdb_valid_o = valid_q;
  assign cdb_data_o  = out_q;

endmodule
